// File: rtl/conbus_pack.sv
// Shared definitions for the conbus round-robin arbiter slice.
// Master count, grant width, arbiter state encoding, pointer helper.
package conbus_pack;

  localparam int m_number = 8;
  localparam int gnt_bits = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TO_WAIT
  } arb_state_t;

  // Next master index, wrapping m_number-1 -> 0.
  function automatic logic [gnt_bits-1:0] wrap_inc(
    input logic [gnt_bits-1:0] i
  );
    if (i == gnt_bits'(m_number - 1))
      return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/conbus_rr_arb_if.sv
// Arbiter bundle: master cyc lines and slave response in; grant, error, busy out.
// master: drives req/ack/err/rty. slave: the arbiter side.
interface conbus_rr_arb_if;
  import conbus_pack::*;

  logic [m_number-1:0] req_i;
  logic                ack_i;
  logic                err_i;
  logic                rty_i;
  logic [gnt_bits-1:0] gnt_o;
  logic                gnt_valid_o;
  logic                to_err_o;
  logic                busy_o;

  modport master (
    output req_i, ack_i, err_i, rty_i,
    input  gnt_o, gnt_valid_o, to_err_o, busy_o
  );

  modport slave (
    input  req_i, ack_i, err_i, rty_i,
    output gnt_o, gnt_valid_o, to_err_o, busy_o
  );

endinterface

// File: rtl/conbus_rr_pick.sv
// Combinational rotate-priority encoder: first set, non-excluded req bit
// at or after start (wrapping) -> winner index, found flag.
module conbus_rr_pick
  import conbus_pack::*;
(
  input  logic [m_number-1:0] req,
  input  logic [gnt_bits-1:0] start,
  input  logic [m_number-1:0] excl,
  output logic [gnt_bits-1:0] winner,
  output logic                found
);

  logic [gnt_bits-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = start;
    for (int i = 0; i < m_number; i++) begin
      if (!found && req[idx] && !excl[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/conbus_rr_arb.sv
// Round-robin arbiter for one conbus slave port, with bus watchdog.
// Ports: clk_i, rst_i (sync, high), bus (slave modport of conbus_rr_arb_if).
module conbus_rr_arb
  import conbus_pack::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  conbus_rr_arb_if.slave  bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [gnt_bits-1:0] LAST_INIT =
    gnt_bits'(m_number - 1);

  arb_state_t          state;
  logic [gnt_bits-1:0] last;
  logic [gnt_bits-1:0] gnt_q;
  logic [CW-1:0]       cnt;
  logic                valid_q;
  logic                to_err_q;
  logic                busy_q;

  logic [m_number-1:0] excl;
  logic [gnt_bits-1:0] win;
  logic                found;
  logic                own_req;
  logic                resp;
  logic                expire;

  // Outside IDLE the current owner is excluded so that a
  // release hands over directly to the next requester.
  always_comb begin
    excl = '0;
    if (state != IDLE)
      excl[gnt_q] = 1'b1;
  end

  conbus_rr_pick u_pick (
    .req    (bus.req_i),
    .start  (wrap_inc(last)),
    .excl   (excl),
    .winner (win),
    .found  (found)
  );

  assign own_req = bus.req_i[gnt_q];
  assign resp    = bus.ack_i | bus.err_i | bus.rty_i;
  assign expire  = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last     <= LAST_INIT;
      gnt_q    <= '0;
      cnt      <= '0;
      valid_q  <= 1'b0;
      to_err_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            state   <= GRANT;
            gnt_q   <= win;
            last    <= win;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        GRANT, TO_WAIT: begin
          if (!own_req) begin
            cnt <= '0;
            if (found) begin
              state   <= GRANT;
              gnt_q   <= win;
              last    <= win;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else if (state == TO_WAIT) begin
            cnt <= '0;
          end else if (resp) begin
            cnt <= '0;
          end else if (expire) begin
            // Isolate the slave; owner sees one err pulse.
            state    <= TO_WAIT;
            valid_q  <= 1'b0;
            to_err_q <= 1'b1;
            cnt      <= '0;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = valid_q;
  assign bus.to_err_o    = to_err_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_conbus_rr_arb.sv
// Self-checking bench for conbus_rr_arb (TIMEOUT=4).
// Directed table, hand sequences for the watchdog, random vs reference model.
module tb_conbus_rr_arb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req_v = '0;
  logic ack_v = 1'b0;
  logic err_v = 1'b0;
  logic rty_v = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conbus_rr_arb_if bus();

  assign bus.req_i = req_v;
  assign bus.ack_i = ack_v;
  assign bus.err_i = err_v;
  assign bus.rty_i = rty_v;

  conbus_rr_arb #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string      nm;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    int         gnt;
    logic       v;
    logic       te;
    logic       b;
  } vec_t;

  vec_t tab[$];

  // Reference model state
  logic m_busy = 0, m_valid = 0, m_te = 0, m_wait = 0;
  int   m_gnt = 0, m_last = 7, m_cnt = 0;

  function automatic int pick(logic [7:0] r, int after, int skip);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (after + k) % 8;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  task automatic m_grant(int w);
    m_gnt = w; m_last = w;
    m_valid = 1; m_busy = 1; m_wait = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_te = 0; m_wait = 0;
      m_gnt = 0; m_last = 7; m_cnt = 0;
    end else begin
      m_te = 0;
      if (!m_busy) begin
        w = pick(req_v, m_last, -1);
        if (w >= 0) m_grant(w);
      end else if (!req_v[m_gnt]) begin
        w = pick(req_v, m_last, m_gnt);
        if (w >= 0) m_grant(w);
        else begin
          m_busy = 0; m_valid = 0; m_wait = 0; m_cnt = 0;
        end
      end else if (!m_wait) begin
        if (ack_v || err_v || rty_v) m_cnt = 0;
        else if (m_cnt == TO - 1) begin
          m_te = 1; m_wait = 1; m_valid = 0; m_cnt = 0;
        end else m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string nm, int g, logic v, logic te, logic b);
    tests++;
    if (int'(bus.gnt_o) != g || bus.gnt_valid_o !== v ||
        bus.to_err_o !== te || bus.busy_o !== b) begin
      fails++;
      $display("FAIL %s: got gnt=%0d v=%0b te=%0b busy=%0b, want gnt=%0d v=%0b te=%0b busy=%0b",
               nm, bus.gnt_o, bus.gnt_valid_o, bus.to_err_o, bus.busy_o,
               g, v, te, b);
    end
  endtask

  task automatic add(string nm, logic r, logic [7:0] q, logic a,
                     int g, logic v, logic te, logic b);
    vec_t e;
    e.nm = nm; e.rst = r; e.req = q; e.ack = a;
    e.gnt = g; e.v = v; e.te = te; e.b = b;
    tab.push_back(e);
  endtask

  task automatic drive(logic [7:0] q, logic a);
    rst = 1'b0; req_v = q; ack_v = a; err_v = 1'b0; rty_v = 1'b0;
  endtask

  initial begin
    logic [7:0] m;

    // Reset and idle
    add("reset", 1, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add("idle", 0, 8'h00, 0, 0, 0, 0, 0);
    // Full round robin, 2-cycle holds, no bubbles
    add("rr_first", 0, 8'hFF, 0, 0, 1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      m = 8'hFF;
      m[k] = 1'b0;
      add("rr_hold", 0, 8'hFF, 0, k, 1, 0, 1);
      add("rr_next", 0, m, 0, (k + 1) % 8, 1, 0, 1);
    end
    // No preemption, hand-over 3 -> 6
    add("reset2", 1, 8'h00, 0, 0, 0, 0, 0);
    add("g3", 0, 8'h08, 0, 3, 1, 0, 1);
    add("g3_hold", 0, 8'h48, 0, 3, 1, 0, 1);
    add("g3_hold2", 0, 8'h48, 0, 3, 1, 0, 1);
    add("g6", 0, 8'h40, 0, 6, 1, 0, 1);
    add("rel_idle", 0, 8'h00, 0, 6, 0, 0, 0);
    // Reset mid-grant
    add("g5", 0, 8'h20, 0, 5, 1, 0, 1);
    add("rst_mid", 1, 8'h20, 0, 0, 0, 0, 0);
    add("post_g0", 0, 8'h21, 0, 0, 1, 0, 1);
    add("post_g5", 0, 8'h20, 0, 5, 1, 0, 1);
    add("post_idle", 0, 8'h00, 0, 5, 0, 0, 0);

    foreach (tab[i]) begin
      rst = tab[i].rst; req_v = tab[i].req; ack_v = tab[i].ack;
      err_v = 1'b0; rty_v = 1'b0;
      step();
      chk(tab[i].nm, tab[i].gnt, tab[i].v, tab[i].te, tab[i].b);
    end

    // Watchdog expiry: pointer at 5, master 2 wins
    drive(8'h04, 0);
    step(); chk("wd_grant", 2, 1, 0, 1);
    for (int i = 1; i < 4; i++) begin
      step(); chk("wd_count", 2, 1, 0, 1);
    end
    step(); chk("wd_pulse", 2, 0, 1, 1);
    step(); chk("wd_wait1", 2, 0, 0, 1);
    step(); chk("wd_wait2", 2, 0, 0, 1);
    drive(8'h00, 0);
    step(); chk("wd_release", 2, 0, 0, 0);

    // Response on expiry cycle beats the watchdog
    drive(8'h04, 0);
    step(); chk("ak_grant", 2, 1, 0, 1);
    for (int i = 1; i < 4; i++) begin
      step(); chk("ak_count", 2, 1, 0, 1);
    end
    drive(8'h04, 1);
    step(); chk("ak_save", 2, 1, 0, 1);
    drive(8'h04, 0);
    for (int i = 1; i < 4; i++) begin
      step(); chk("ak_recount", 2, 1, 0, 1);
    end
    step(); chk("ak_pulse", 2, 0, 1, 1);
    drive(8'h00, 0);
    step(); chk("ak_release", 2, 0, 0, 0);

    // Random traffic against the reference model
    rst = 1'b1; req_v = '0; ack_v = 0;
    step(); chk("rnd_reset", m_gnt, m_valid, m_te, m_busy);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) req_v[b] = ~req_v[b];
      ack_v = ($urandom_range(0, 5) == 0);
      err_v = ($urandom_range(0, 30) == 0);
      rty_v = ($urandom_range(0, 30) == 0);
      step();
      chk("random", m_gnt, m_valid, m_te, m_busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
